// File: rtl/pe_operand_feeder_if.sv
// Operand-feeder bundle: loader push side, start/status, PE operand/accumulator side.
// Latency: none (wires only).
// Backpressure: the loader watches full/count; wr_en while full is dropped by the feeder.
// Ports: master = loader + pe_mac environment; slave = pe_operand_feeder.
interface pe_operand_feeder_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN_W  = 5
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_a;
  logic [DATA_W-1:0] wr_b;
  logic              full;
  logic [LEN_W-1:0]  count;
  logic              start;
  logic [LEN_W-1:0]  vec_len;
  logic              start_err;
  logic              busy;
  logic              pe_clr;
  logic              valid;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [ACC_W-1:0]  acc_in;
  logic [ACC_W-1:0]  result;
  logic              result_valid;

  modport master (
    output wr_en, wr_a, wr_b, start, vec_len, acc_in,
    input  full, count, start_err, busy, pe_clr, valid, a, b, result, result_valid
  );

  modport slave (
    input  wr_en, wr_a, wr_b, start, vec_len, acc_in,
    output full, count, start_err, busy, pe_clr, valid, a, b, result, result_valid
  );
endinterface

// File: rtl/pe_operand_feeder.sv
// Buffers (a,b) pairs in a circular FIFO and streams vec_len of them into one pe_mac.
// Latency: start -> pe_clr next cycle, first valid 2 cycles after start, result_valid vec_len+3.
// Backpressure: none toward the PE; pushes while full are dropped, bad starts pulse start_err.
// Ports: clk, rst (sync, active-high), bus (slave side of pe_operand_feeder_if).
module pe_operand_feeder #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  pe_operand_feeder_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  remaining;
  logic [DATA_W-1:0] a_q, b_q;
  logic [ACC_W-1:0]  result_q;
  logic              start_err_q;
  logic              full;
  logic              push, pop;
  logic              len_ok, start_take;

  assign full   = (cnt == LEN_W'(DEPTH));
  assign push   = bus.wr_en && !full;
  // vec_len <= cnt already implies <= DEPTH; the explicit bound keeps intent obvious.
  assign len_ok = (bus.vec_len != '0) && (bus.vec_len <= LEN_W'(DEPTH)) && (bus.vec_len <= cnt);
  assign start_take = (state == IDLE) && bus.start && len_ok;

  // Next state; pop is asserted on every edge that enters or stays in STREAM so the
  // registered a/b hold the head pair for exactly the cycle valid is high.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:   if (start_take) state_nxt = CLEAR;
      CLEAR:  begin
        state_nxt = STREAM;
        pop       = 1'b1;
      end
      STREAM: begin
        if (remaining != '0) pop = 1'b1;
        else                 state_nxt = DRAIN;
      end
      DRAIN:  state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.wr_a;
      mem_b[wr_ptr] <= bus.wr_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      remaining   <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      start_err_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      start_err_q <= (state == IDLE) && bus.start && !len_ok;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      if (start_take) remaining <= bus.vec_len;
      else if (pop)   remaining <= remaining - 1'b1;

      // Operands are zero whenever valid is low.
      if (pop) begin
        a_q <= mem_a[rd_ptr];
        b_q <= mem_b[rd_ptr];
      end else begin
        a_q <= '0;
        b_q <= '0;
      end

      // In DRAIN the PE accumulator already includes the last product.
      if (state == DRAIN) result_q <= bus.acc_in;
    end
  end

  assign bus.full         = full;
  assign bus.count        = cnt;
  assign bus.start_err    = start_err_q;
  assign bus.busy         = (state != IDLE);
  assign bus.pe_clr       = (state == CLEAR);
  assign bus.valid        = (state == STREAM);
  assign bus.a            = a_q;
  assign bus.b            = b_q;
  assign bus.result       = result_q;
  assign bus.result_valid = (state == DONE);
endmodule

// File: tb/tb_pe_operand_feeder.sv
module tb_pe_operand_feeder;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int DEPTH  = 16;
  localparam int LEN_W  = 5;

  logic clk = 1'b0;
  logic rst;

  pe_operand_feeder_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  pe_operand_feeder #(.DATA_W(DATA_W), .ACC_W(ACC_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // pe_mac stand-in: clear on rst or pe_clr, accumulate a*b when valid.
  logic [ACC_W-1:0] pe_acc;
  always_ff @(posedge clk) begin
    if (rst || bus.pe_clr) pe_acc <= '0;
    else if (bus.valid)    pe_acc <= pe_acc + ACC_W'(bus.a) * ACC_W'(bus.b);
  end
  assign bus.acc_in = pe_acc;

  int checks   = 0;
  int failures = 0;
  logic [15:0] pq[$];  // expected FIFO contents, {a,b}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input int av, input int bv);
    bus.wr_en = 1'b1;
    bus.wr_a  = DATA_W'(av);
    bus.wr_b  = DATA_W'(bv);
    if (pq.size() < DEPTH) pq.push_back({8'(av), 8'(bv)});
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic reject(input int len, input int exp_count);
    bus.start   = 1'b1;
    bus.vec_len = LEN_W'(len);
    step();
    bus.start = 1'b0;
    chk("rej_err_pulse", bus.start_err, 1);
    chk("rej_no_clr",    bus.pe_clr, 0);
    chk("rej_not_busy",  bus.busy, 0);
    chk("rej_count",     bus.count, exp_count);
    step();
    chk("rej_err_drop",  bus.start_err, 0);
    chk("rej_no_valid",  bus.valid, 0);
  endtask

  // Starts a dot product and checks every cycle of it; optional pushes during STREAM.
  task automatic run_dot(input int len, input bit push_during, input bit use_const,
                         input int const_exp);
    int sum;
    logic [15:0] p;
    sum = 0;
    bus.start   = 1'b1;
    bus.vec_len = LEN_W'(len);
    step();
    bus.start = 1'b0;
    chk("clr_pulse", bus.pe_clr, 1);
    chk("clr_valid", bus.valid, 0);
    chk("clr_busy",  bus.busy, 1);
    step();
    for (int i = 0; i < len; i++) begin
      p = (pq.size() > 0) ? pq.pop_front() : 16'h0;
      sum += int'(p[15:8]) * int'(p[7:0]);
      chk("stream_valid", bus.valid, 1);
      chk("stream_clr",   bus.pe_clr, 0);
      chk("stream_a",     bus.a, p[15:8]);
      chk("stream_b",     bus.b, p[7:0]);
      chk("stream_count", bus.count, pq.size());
      if (push_during) begin
        bus.wr_en = 1'b1;
        bus.wr_a  = DATA_W'(100 + i);
        bus.wr_b  = DATA_W'(i + 1);
        pq.push_back({8'(100 + i), 8'(i + 1)});
      end
      step();
    end
    bus.wr_en = 1'b0;
    chk("drain_valid", bus.valid, 0);
    chk("drain_a",     bus.a, 0);
    chk("drain_b",     bus.b, 0);
    chk("drain_rv",    bus.result_valid, 0);
    step();
    chk("done_rv",     bus.result_valid, 1);
    chk("done_result", bus.result, use_const ? const_exp : (sum & 16'hffff));
    step();
    chk("post_rv",     bus.result_valid, 0);
    chk("post_busy",   bus.busy, 0);
    chk("post_count",  bus.count, pq.size());
    chk("post_hold",   bus.result, use_const ? const_exp : (sum & 16'hffff));
  endtask

  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_a    = '0;
    bus.wr_b    = '0;
    bus.start   = 1'b0;
    bus.vec_len = '0;
    step();
    step();
    chk("rst_full",   bus.full, 0);
    chk("rst_count",  bus.count, 0);
    chk("rst_busy",   bus.busy, 0);
    chk("rst_valid",  bus.valid, 0);
    chk("rst_clr",    bus.pe_clr, 0);
    chk("rst_err",    bus.start_err, 0);
    chk("rst_a",      bus.a, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_rv",     bus.result_valid, 0);
    rst = 1'b0;
    step();

    // Basic two-pair dot product: 2*3 + 4*5 = 26.
    push_pair(2, 3);
    push_pair(4, 5);
    chk("s1_count", bus.count, 2);
    run_dot(2, 1'b0, 1'b1, 26);

    // Rejected starts leave the buffered pair alone; then drain it with vec_len=1.
    push_pair(7, 9);
    reject(2, 1);
    reject(0, 1);
    reject(17, 1);
    run_dot(1, 1'b0, 1'b1, 63);

    // Fill to full, drop the 17th pair, stream all 16: sum k*(k+1) = 1360.
    for (int k = 0; k < 17; k++) begin
      push_pair(k, k + 1);
      if (k == 14) chk("s3_not_full", bus.full, 0);
      if (k == 15) chk("s3_full", bus.full, 1);
    end
    chk("s3_count_sat", bus.count, 16);
    chk("s3_full_hold", bus.full, 1);
    run_dot(16, 1'b0, 1'b1, 1360);
    chk("s3_empty", bus.count, 0);

    // Pushes overlapping STREAM stay buffered for the next vector.
    push_pair(3, 4);
    push_pair(5, 6);
    run_dot(2, 1'b1, 1'b1, 42);
    chk("s4_left", bus.count, 2);
    run_dot(2, 1'b0, 1'b1, 100 * 1 + 101 * 2);

    // Three rounds of ten across the pointer wrap.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) push_pair(r * 10 + i + 1, i + 3);
      chk("s5_count", bus.count, 10);
      run_dot(10, 1'b0, 1'b0, 0);
    end

    // Reset in the middle of STREAM aborts everything.
    for (int i = 1; i <= 4; i++) push_pair(i, i);
    bus.start   = 1'b1;
    bus.vec_len = LEN_W'(4);
    step();
    bus.start = 1'b0;
    step();
    step();
    chk("s6_mid_valid", bus.valid, 1);
    rst = 1'b1;
    step();
    chk("s6_valid",  bus.valid, 0);
    chk("s6_busy",   bus.busy, 0);
    chk("s6_count",  bus.count, 0);
    chk("s6_result", bus.result, 0);
    chk("s6_rv",     bus.result_valid, 0);
    rst = 1'b0;
    pq.delete();
    step();
    chk("s6_rv_after", bus.result_valid, 0);
    push_pair(2, 3);
    push_pair(4, 5);
    run_dot(2, 1'b0, 1'b1, 26);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
